// File: rtl/addsub_arbiter_if.sv
// addsub_arbiter_if: requester, result and counter handshake bundle.
// Counter signals exist only when ADDSUB_ARB_OVF_COUNT_EN is defined.
interface addsub_arbiter_if;
  logic       req0_valid;
  logic [7:0] req0_a;
  logic [7:0] req0_b;
  logic       req0_op;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_a;
  logic [7:0] req1_b;
  logic       req1_op;
  logic       req1_ready;
  logic       res_valid;
  logic       res_ready;
  logic       res_id;
  logic [7:0] res_sum;
  logic       res_carry;
  logic       res_overflow;
`ifdef ADDSUB_ARB_OVF_COUNT_EN
  logic       clear_cnt;
  logic [7:0] ovf_cnt0;
  logic [7:0] ovf_cnt1;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  res_valid, res_id, res_sum,
    input  res_carry, res_overflow,
    output res_ready,
    output clear_cnt,
    input  ovf_cnt0, ovf_cnt1
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output res_valid, res_id, res_sum,
    output res_carry, res_overflow,
    input  res_ready,
    input  clear_cnt,
    output ovf_cnt0, ovf_cnt1
  );
`else
  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  res_valid, res_id, res_sum,
    input  res_carry, res_overflow,
    output res_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output res_valid, res_id, res_sum,
    output res_carry, res_overflow,
    input  res_ready
  );
`endif
endinterface

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: two requesters share one 8-bit add/sub, registered result.
// Optional overflow counters under ADDSUB_ARB_OVF_COUNT_EN.
module addsub_arbiter #(
  parameter bit FAIR  = 1'b1,
  parameter bit FIRST = 1'b0
) (
  input logic              clk,
  input logic              reset,
  addsub_arbiter_if.slave  bus
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t     state;
  state_t     state_nx;
  logic       ptr;
  logic       can_accept;
  logic       g0;
  logic       g1;
  logic       acc;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] beff;
  logic       op;
  logic [8:0] wide;
  logic [7:0] sum;
  logic       carry;
  logic       ovf;

  logic       r_id;
  logic [7:0] r_sum;
  logic       r_carry;
  logic       r_ovf;

  // ptr names the requester that wins the next two-way contention
  always_comb begin
    can_accept = (state == EMPTY) || bus.res_ready;
    g0 = 1'b0;
    g1 = 1'b0;
    if (can_accept) begin
      unique case (1'b1)
        bus.req0_valid && bus.req1_valid: begin
          if (!FAIR || !ptr) g0 = 1'b1;
          else               g1 = 1'b1;
        end
        bus.req0_valid && !bus.req1_valid: g0 = 1'b1;
        bus.req1_valid && !bus.req0_valid: g1 = 1'b1;
        default: ;
      endcase
    end
  end

  assign acc = g0 | g1;

  always_comb begin
    a    = g1 ? bus.req1_a  : bus.req0_a;
    b    = g1 ? bus.req1_b  : bus.req0_b;
    op   = g1 ? bus.req1_op : bus.req0_op;
    beff = b ^ {8{op}};
    wide = {1'b0, a} + {1'b0, beff} + {8'd0, op};
    sum   = wide[7:0];
    carry = wide[8];
    ovf   = (a[7] == beff[7]) && (sum[7] != a[7]);
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      EMPTY: if (acc) state_nx = FULL;
      FULL:  if (bus.res_ready && !acc) state_nx = EMPTY;
      default: state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr     <= FIRST;
      r_id    <= 1'b0;
      r_sum   <= 8'd0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (acc) begin
      ptr     <= ~g1;
      r_id    <= g1;
      r_sum   <= sum;
      r_carry <= carry;
      r_ovf   <= ovf;
    end
  end

  assign bus.req0_ready   = g0;
  assign bus.req1_ready   = g1;
  assign bus.res_valid    = (state == FULL);
  assign bus.res_id       = r_id;
  assign bus.res_sum      = r_sum;
  assign bus.res_carry    = r_carry;
  assign bus.res_overflow = r_ovf;

`ifdef ADDSUB_ARB_OVF_COUNT_EN
  logic [7:0] cnt0;
  logic [7:0] cnt1;

  // clear takes precedence over a coinciding increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0 <= 8'd0;
      cnt1 <= 8'd0;
    end else if (bus.clear_cnt) begin
      cnt0 <= 8'd0;
      cnt1 <= 8'd0;
    end else begin
      if (g0 && ovf && cnt0 != 8'hff) cnt0 <= cnt0 + 8'd1;
      if (g1 && ovf && cnt1 != 8'hff) cnt1 <= cnt1 + 8'd1;
    end
  end

  assign bus.ovf_cnt0 = cnt0;
  assign bus.ovf_cnt1 = cnt1;
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: scoreboard bench, round-robin and fixed-priority copies.
// Shared stimulus drives both; ADDSUB_ARB_OVF_COUNT_EN adds counter checks.
module tb_addsub_arbiter;

  localparam bit FIRST = 1'b0;

  logic clk = 1'b0;
  logic reset;
  logic v0, v1, op0, op1, rr, clr;
  logic [7:0] a0, b0, a1, b1;

  always #5 clk = ~clk;

  addsub_arbiter_if bf ();
  addsub_arbiter_if bp ();

  addsub_arbiter #(.FAIR(1'b1), .FIRST(FIRST)) u_fair (
    .clk(clk), .reset(reset), .bus(bf.slave)
  );
  addsub_arbiter #(.FAIR(1'b0), .FIRST(FIRST)) u_fix (
    .clk(clk), .reset(reset), .bus(bp.slave)
  );

  assign bf.req0_valid = v0;
  assign bf.req0_a     = a0;
  assign bf.req0_b     = b0;
  assign bf.req0_op    = op0;
  assign bf.req1_valid = v1;
  assign bf.req1_a     = a1;
  assign bf.req1_b     = b1;
  assign bf.req1_op    = op1;
  assign bf.res_ready  = rr;
  assign bp.req0_valid = v0;
  assign bp.req0_a     = a0;
  assign bp.req0_b     = b0;
  assign bp.req0_op    = op0;
  assign bp.req1_valid = v1;
  assign bp.req1_a     = a1;
  assign bp.req1_b     = b1;
  assign bp.req1_op    = op1;
  assign bp.res_ready  = rr;

  logic       rv[2];
  logic       rdy0[2];
  logic       rdy1[2];
  logic       rid[2];
  logic [7:0] rs[2];
  logic       rc[2];
  logic       ro[2];

  assign rv[0]   = bf.res_valid;
  assign rv[1]   = bp.res_valid;
  assign rdy0[0] = bf.req0_ready;
  assign rdy0[1] = bp.req0_ready;
  assign rdy1[0] = bf.req1_ready;
  assign rdy1[1] = bp.req1_ready;
  assign rid[0]  = bf.res_id;
  assign rid[1]  = bp.res_id;
  assign rs[0]   = bf.res_sum;
  assign rs[1]   = bp.res_sum;
  assign rc[0]   = bf.res_carry;
  assign rc[1]   = bp.res_carry;
  assign ro[0]   = bf.res_overflow;
  assign ro[1]   = bp.res_overflow;

`ifdef ADDSUB_ARB_OVF_COUNT_EN
  logic [7:0] oc0[2];
  logic [7:0] oc1[2];
  assign bf.clear_cnt = clr;
  assign bp.clear_cnt = clr;
  assign oc0[0] = bf.ovf_cnt0;
  assign oc0[1] = bp.ovf_cnt0;
  assign oc1[0] = bf.ovf_cnt1;
  assign oc1[1] = bp.ovf_cnt1;
`endif

  typedef struct packed {
    logic       id;
    logic [7:0] sum;
    logic       c;
    logic       o;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  bit   mfull[2];
  bit   mptr[2];
  int   mcnt0[2];
  int   mcnt1[2];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // signed/unsigned integer reference for sum, carry and overflow
  function automatic logic [9:0] ref_calc(logic [7:0] a, logic [7:0] b,
                                          logic op);
    int sa, sb, full;
    logic c, o;
    sa = $signed(a);
    sb = $signed(b);
    full = op ? sa - sb : sa + sb;
    o = (full > 127) || (full < -128);
    c = op ? (a >= b) : ((int'(a) + int'(b)) > 255);
    return {c, o, full[7:0]};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (reset) begin
        q0.delete();
        q1.delete();
        for (int k = 0; k < 2; k++) begin
          mfull[k] = 1'b0;
          mptr[k]  = FIRST;
          mcnt0[k] = 0;
          mcnt1[k] = 0;
        end
      end else begin
        for (int k = 0; k < 2; k++) begin
          exp_t e;
          bit ok, fair, ca, g0, g1;
          logic [9:0] r;
          chk($sformatf("res_valid[%0d]", k), rv[k], mfull[k]);
          if (rv[k] && rr) begin
            ok = (k == 0) ? (q0.size() != 0) : (q1.size() != 0);
            if (!ok) chk($sformatf("unexpected result[%0d]", k), 1, 0);
            else begin
              e = (k == 0) ? q0.pop_front() : q1.pop_front();
              chk($sformatf("res_id[%0d]", k), rid[k], e.id);
              chk($sformatf("res_sum[%0d]", k), rs[k], e.sum);
              chk($sformatf("res_carry[%0d]", k), rc[k], e.c);
              chk($sformatf("res_ovf[%0d]", k), ro[k], e.o);
            end
          end
          fair = (k == 0);
          ca = !mfull[k] || rr;
          g0 = ca && v0 && (!v1 || !fair || !mptr[k]);
          g1 = ca && v1 && !g0;
          chk($sformatf("req0_ready[%0d]", k), rdy0[k], g0);
          chk($sformatf("req1_ready[%0d]", k), rdy1[k], g1);
          if (g0 || g1) begin
            r = g0 ? ref_calc(a0, b0, op0) : ref_calc(a1, b1, op1);
            e.id = g1;
            e.sum = r[7:0];
            e.o = r[8];
            e.c = r[9];
            if (k == 0) q0.push_back(e);
            else        q1.push_back(e);
            if (g0 && e.o && mcnt0[k] < 255) mcnt0[k]++;
            if (g1 && e.o && mcnt1[k] < 255) mcnt1[k]++;
            mfull[k] = 1'b1;
            mptr[k]  = g0;
          end else if (rr) begin
            mfull[k] = 1'b0;
          end
          if (clr) begin
            mcnt0[k] = 0;
            mcnt1[k] = 0;
          end
        end
      end
    end
  endtask

  initial begin
    fork
      monitor_loop();
    join_none
    reset = 1'b1;
    {v0, v1, op0, op1, rr, clr} = '0;
    {a0, b0, a1, b1} = '0;
    #2;
    for (int k = 0; k < 2; k++) begin
      chk("reset res_valid", rv[k], 0);
      chk("reset res_id", rid[k], 0);
      chk("reset res_sum", rs[k], 0);
      chk("reset res_carry", rc[k], 0);
      chk("reset res_ovf", ro[k], 0);
    end
    cyc();
    cyc();
    reset = 1'b0;

    // both requesters every cycle: -128-(-128) and -127+127
    rr = 1'b1;
    v0 = 1'b1; a0 = 8'h80; b0 = 8'h80; op0 = 1'b1;
    v1 = 1'b1; a1 = 8'h81; b1 = 8'h7f; op1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("alternating grant0", rdy0[0], (i % 2 == 0));
      chk("alternating grant1", rdy1[0], (i % 2 == 1));
      chk("fixed prio grant1", rdy1[1], 0);
      if (i > 0) begin
        chk("alt sum", rs[0], 0);
        chk("alt carry", rc[0], 1);
        chk("alt ovf", ro[0], 0);
      end
    end
    cyc();
    v0 = 1'b0;
    v1 = 1'b0;
    cyc();

    // requester 0 alone: 115 + 30
    v0 = 1'b1; a0 = 8'd115; b0 = 8'd30; op0 = 1'b0;
    @(negedge clk);
    chk("r0 alone ready", rdy0[0], 1);
    cyc();
    v0 = 1'b0;
    @(negedge clk);
    chk("r0 ready one cycle", rdy0[0], 0);
    chk("r0 sum", rs[0], 8'b10010001);
    chk("r0 carry", rc[0], 0);
    chk("r0 ovf", ro[0], 1);
    chk("r0 id", rid[0], 0);
    cyc();

    // requester 1 alone: 68 - (-93)
    v1 = 1'b1; a1 = 8'd68; b1 = 8'hA3; op1 = 1'b1;
    @(negedge clk);
    chk("r1 alone ready", rdy1[0], 1);
    cyc();
    v1 = 1'b0;
    @(negedge clk);
    chk("r1 sum", rs[0], 8'b10100001);
    chk("r1 carry", rc[0], 0);
    chk("r1 ovf", ro[0], 1);
    chk("r1 id", rid[0], 1);
    cyc();

    // backpressure with both requesters pending
    rr = 1'b0;
    v0 = 1'b1; a0 = 8'd10; b0 = 8'd20; op0 = 1'b0;
    v1 = 1'b1; a1 = 8'd50; b1 = 8'd7;  op1 = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk("stall no ready", rdy0[k] | rdy1[k], 0);
        chk("stall held sum", rs[k], 30);
        chk("stall held id", rid[k], 0);
        chk("stall held valid", rv[k], 1);
      end
    end
    cyc();
    rr = 1'b1;
    @(negedge clk);
    chk("release same-cycle grant1", rdy1[0], 1);
    chk("release fixed grant0", rdy0[1], 1);
    @(negedge clk);
    chk("after release sum", rs[0], 43);
    chk("after release id", rid[0], 1);

    // fixed priority keeps requester 1 starved
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("fixed never ready1", rdy1[1], 0);
    end
    cyc();
    v0 = 1'b0;
    v1 = 1'b0;

    // asynchronous reset while holding a result
    cyc();
    rr = 1'b0;
    v0 = 1'b1; a0 = 8'd100; b0 = 8'd100; op0 = 1'b0;
    cyc();
    v0 = 1'b0;
    #1;
    chk("full before reset", rv[0], 1);
    #1;
    reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("async reset res_valid", rv[k], 0);
      chk("async reset res_sum", rs[k], 0);
      chk("async reset res_id", rid[k], 0);
      chk("async reset res_carry", rc[k], 0);
      chk("async reset res_ovf", ro[k], 0);
    end
    cyc();
    cyc();
    reset = 1'b0;
    rr = 1'b1;

    // one overflowing req1 op, then clear, then 300 req0 overflows
    v1 = 1'b1; a1 = 8'd68; b1 = 8'hA3; op1 = 1'b1;
    cyc();
    v1 = 1'b0;
`ifdef ADDSUB_ARB_OVF_COUNT_EN
    for (int k = 0; k < 2; k++) chk("cnt1 after one", oc1[k], 1);
`endif
    clr = 1'b1;
    cyc();
    clr = 1'b0;
`ifdef ADDSUB_ARB_OVF_COUNT_EN
    for (int k = 0; k < 2; k++) chk("cnt1 cleared", oc1[k], 0);
`endif
    v0 = 1'b1; a0 = 8'd115; b0 = 8'd30; op0 = 1'b0;
    repeat (300) @(negedge clk);
`ifdef ADDSUB_ARB_OVF_COUNT_EN
    for (int k = 0; k < 2; k++) begin
      chk("cnt0 saturated", oc0[k], 255);
      chk("cnt0 model", oc0[k], mcnt0[k]);
      chk("cnt1 idle", oc1[k], 0);
    end
`endif
    cyc();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    v0 = 1'b0;
    #1;
`ifdef ADDSUB_ARB_OVF_COUNT_EN
    for (int k = 0; k < 2; k++) begin
      chk("clear beats incr", oc0[k], 0);
      chk("clear model", oc0[k], mcnt0[k]);
    end
`endif

    repeat (3) cyc();
    @(negedge clk);
    chk("scoreboard drained", q0.size() + q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
